// File: rtl/arm1_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : arm1_mem_arbiter_if
// Brief    : Core/host request ports and memory-side bus of the ARM1 arbiter.
// Revision : 1.0
// ============================================================================
interface arm1_mem_arbiter_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_ack;
  logic [DATA_W-1:0] host_rdata;
  logic              host_lock;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  host_req, host_we, host_addr, host_wdata, host_lock,
    input  mem_rdata,
    output cpu_ack, cpu_rdata, cpu_stall,
    output host_ack, host_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output host_req, host_we, host_addr, host_wdata, host_lock,
    output mem_rdata,
    input  cpu_ack, cpu_rdata, cpu_stall,
    input  host_ack, host_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/arm1_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : arm1_mem_arbiter
// Brief    : Round-robin core/host arbiter for the ARM1 single-port memory.
// Revision : 1.0
// ============================================================================
module arm1_mem_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  wire logic         clk,
  input  wire logic         reset,
  arm1_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic PORT_CPU  = 1'b0;
  localparam logic PORT_HOST = 1'b1;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] host_rdata_q, host_rdata_d;

  logic              in_resp;
  logic              cpu_cand;
  logic              host_cand;
  logic              any_cand;
  logic              grant_port;

  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              mem_en;
  logic              cpu_ack;
  logic              host_ack;

  // The port being acked in RESP sits out one arbitration round.
  always_comb begin
    in_resp   = (state_q == ST_RESP);
    cpu_cand  = bus.cpu_req & ~bus.host_lock & ~(in_resp & (owner_q == PORT_CPU));
    host_cand = bus.host_req & ~(in_resp & (owner_q == PORT_HOST));
    any_cand  = cpu_cand | host_cand;
    if (cpu_cand & host_cand) begin
      grant_port = ~last_q;
    end else if (host_cand) begin
      grant_port = PORT_HOST;
    end else begin
      grant_port = PORT_CPU;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_d       = last_q;
    we_d         = we_q;
    cpu_rdata_d  = cpu_rdata_q;
    host_rdata_d = host_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (any_cand) begin
          owner_d = grant_port;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        last_d  = owner_q;
        we_d    = sel_we;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (!we_q) begin
          if (owner_q == PORT_HOST) begin
            host_rdata_d = bus.mem_rdata;
          end else begin
            cpu_rdata_d = bus.mem_rdata;
          end
        end
        if (any_cand) begin
          owner_d = grant_port;
          state_d = ST_ACCESS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= PORT_CPU;
      last_q       <= PORT_HOST;
      we_q         <= 1'b0;
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_q       <= last_d;
      we_q         <= we_d;
      cpu_rdata_q  <= cpu_rdata_d;
      host_rdata_q <= host_rdata_d;
    end
  end

  assign sel_we    = (owner_q == PORT_HOST) ? bus.host_we    : bus.cpu_we;
  assign sel_addr  = (owner_q == PORT_HOST) ? bus.host_addr  : bus.cpu_addr;
  assign sel_wdata = (owner_q == PORT_HOST) ? bus.host_wdata : bus.cpu_wdata;

  assign mem_en   = (state_q == ST_ACCESS);
  assign cpu_ack  = in_resp & (owner_q == PORT_CPU);
  assign host_ack = in_resp & (owner_q == PORT_HOST);

  // Memory bus is quiet (all zero) whenever no access is in flight.
  assign bus.mem_en    = mem_en;
  assign bus.mem_we    = mem_en & sel_we;
  assign bus.mem_addr  = mem_en ? sel_addr  : '0;
  assign bus.mem_wdata = mem_en ? sel_wdata : '0;

  // Read data is forwarded straight from memory in the ack cycle, then held.
  assign bus.cpu_ack    = cpu_ack;
  assign bus.host_ack   = host_ack;
  assign bus.cpu_rdata  = (cpu_ack  & ~we_q) ? bus.mem_rdata : cpu_rdata_q;
  assign bus.host_rdata = (host_ack & ~we_q) ? bus.mem_rdata : host_rdata_q;
  assign bus.cpu_stall  = bus.cpu_req & ~cpu_ack;

endmodule
`default_nettype wire

// File: tb/tb_arm1_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_arm1_mem_arbiter
// Brief    : Directed and randomized checks of arm1_mem_arbiter against a
//            transaction-level reference model.
// Revision : 1.0
// ============================================================================
module tb_arm1_mem_arbiter;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int N_RAND = 3000;
  localparam int N_LIT  = 160;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  arm1_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  arm1_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Synchronous-read memory array with a preload path used while idle.
  logic [7:0] phys_mem [16];
  logic       pl_en   = 1'b0;
  logic [3:0] pl_addr = 4'd0;
  logic [7:0] pl_data = 8'd0;

  always @(posedge clk) begin
    if (pl_en) begin
      phys_mem[pl_addr] <= pl_data;
    end else if (bus.mem_en) begin
      if (bus.mem_we) phys_mem[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= phys_mem[bus.mem_addr];
    end
  end

  // Hand-computed expectations, scheduled by cycle number.
  int    lit_cyc  [N_LIT];
  int    lit_sig  [N_LIT];
  int    lit_arg  [N_LIT];
  int    lit_exp  [N_LIT];
  string lit_name [N_LIT];
  int    n_lits = 0;
  int    lit_rd = 0;
  bit    forbid_cpu_ack = 1'b0;

  int cyc      = 0;
  int checks   = 0;
  int failures = 0;

  // Reference model: one outstanding transaction, aged in cycles since grant.
  logic [7:0] ref_mem [16];
  logic [7:0] m_rd [2];
  bit         m_busy = 1'b0;
  int         m_age  = 0;
  bit         m_last = 1'b1;
  bit         t_port, t_we;
  logic [3:0] t_addr;
  logic [7:0] t_wdata, t_rdata;
  bit         m_acc, m_ack, m_cc, m_hc, m_g;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int lit_actual(input int sig, input int arg);
    case (sig)
      0:       return int'(bus.mem_en);
      1:       return int'(bus.mem_addr);
      2:       return int'(bus.cpu_ack);
      3:       return int'(bus.host_ack);
      4:       return int'(bus.cpu_rdata);
      5:       return int'(bus.host_rdata);
      6:       return int'(bus.cpu_stall);
      7:       return int'(bus.mem_we);
      8:       return int'(phys_mem[arg[3:0]]);
      default: return arg;
    endcase
  endfunction

  always @(negedge clk) begin
    if (pl_en) ref_mem[pl_addr] = pl_data;
    if (!reset) begin
      m_busy = 1'b0;
      m_age  = 0;
      m_last = 1'b1;
      m_rd[0] = 8'd0;
      m_rd[1] = 8'd0;
      chk("rst_mem_en",     int'(bus.mem_en),     0);
      chk("rst_mem_we",     int'(bus.mem_we),     0);
      chk("rst_mem_addr",   int'(bus.mem_addr),   0);
      chk("rst_mem_wdata",  int'(bus.mem_wdata),  0);
      chk("rst_cpu_ack",    int'(bus.cpu_ack),    0);
      chk("rst_host_ack",   int'(bus.host_ack),   0);
      chk("rst_cpu_rdata",  int'(bus.cpu_rdata),  0);
      chk("rst_host_rdata", int'(bus.host_rdata), 0);
    end else begin
      if (m_busy) m_age++;
      m_acc = m_busy && (m_age == 1);
      m_ack = m_busy && (m_age == 2);
      if (m_ack && !t_we) m_rd[t_port] = t_rdata;

      chk("mem_en", int'(bus.mem_en), int'(m_acc));
      chk("mem_we", int'(bus.mem_we), int'(m_acc && t_we));
      if (m_acc) begin
        chk("mem_addr", int'(bus.mem_addr), int'(t_addr));
        if (t_we) chk("mem_wdata", int'(bus.mem_wdata), int'(t_wdata));
      end
      chk("cpu_ack",    int'(bus.cpu_ack),    int'(m_ack && !t_port));
      chk("host_ack",   int'(bus.host_ack),   int'(m_ack && t_port));
      chk("cpu_rdata",  int'(bus.cpu_rdata),  int'(m_rd[0]));
      chk("host_rdata", int'(bus.host_rdata), int'(m_rd[1]));
      chk("cpu_stall",  int'(bus.cpu_stall),  int'(bus.cpu_req && !(m_ack && !t_port)));
      if (forbid_cpu_ack) chk("lock_blocks_cpu", int'(bus.cpu_ack), 0);

      // A new grant is possible when nothing is in flight or in its ack cycle.
      if (!m_busy || m_ack) begin
        m_cc = bus.cpu_req && !bus.host_lock && !(m_ack && !t_port);
        m_hc = bus.host_req && !(m_ack && t_port);
        if (m_cc || m_hc) begin
          m_g     = (m_cc && m_hc) ? !m_last : m_hc;
          t_port  = m_g;
          t_we    = m_g ? bus.host_we    : bus.cpu_we;
          t_addr  = m_g ? bus.host_addr  : bus.cpu_addr;
          t_wdata = m_g ? bus.host_wdata : bus.cpu_wdata;
          if (t_we) ref_mem[t_addr] = t_wdata;
          else      t_rdata = ref_mem[t_addr];
          m_last = m_g;
          m_busy = 1'b1;
          m_age  = 0;
        end else begin
          m_busy = 1'b0;
        end
      end
    end

    while (lit_rd < n_lits && lit_cyc[lit_rd] <= cyc) begin
      chk(lit_name[lit_rd], lit_actual(lit_sig[lit_rd], lit_arg[lit_rd]), lit_exp[lit_rd]);
      lit_rd++;
    end
    cyc++;
  end

  task automatic expect_lit(input int c, input int sig, input int arg, input int e, input string name);
    if (n_lits < N_LIT) begin
      lit_cyc[n_lits]  = c;
      lit_sig[n_lits]  = sig;
      lit_arg[n_lits]  = arg;
      lit_exp[n_lits]  = e;
      lit_name[n_lits] = name;
      n_lits++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pl(input logic [3:0] a, input logic [7:0] d);
    pl_addr = a;
    pl_data = d;
    pl_en   = 1'b1;
    tick();
    pl_en   = 1'b0;
  endtask

  task automatic wait_ack(input bit host, input int bound, input string name);
    bit seen = 1'b0;
    for (int i = 0; i <= bound && !seen; i++) begin
      if (i != 0) tick();
      #1;
      seen = host ? bus.host_ack : bus.cpu_ack;
    end
    if (!seen) expect_lit(cyc, 9, 1, 0, name);
  endtask

  task automatic new_cpu();
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'($urandom_range(1));
    bus.cpu_addr  = 4'($urandom_range(15));
    bus.cpu_wdata = 8'($urandom_range(255));
  endtask

  task automatic new_host();
    bus.host_req   = 1'b1;
    bus.host_we    = 1'($urandom_range(1));
    bus.host_addr  = 4'($urandom_range(15));
    bus.host_wdata = 8'($urandom_range(255));
  endtask

  initial begin
    int c0;
    bit cack, hack;
    bus.cpu_req = 1'b0;  bus.cpu_we = 1'b0;  bus.cpu_addr = '0;  bus.cpu_wdata = '0;
    bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;
    bus.host_lock = 1'b0;

    for (int a = 0; a < 16; a++) pl(4'(a), 8'($urandom_range(255)));
    pl(4'd14, 8'h2A);
    expect_lit(cyc, 0, 0, 0, "rst_idle_mem_en");
    expect_lit(cyc, 4, 0, 0, "rst_idle_cpu_rdata");
    tick();
    reset = 1'b1;

    // Single core read of word 14.
    c0 = cyc;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 4'd14;
    expect_lit(c0,     6, 0, 1,     "rd_stall_c0");
    expect_lit(c0,     0, 0, 0,     "rd_mem_en_c0");
    expect_lit(c0 + 1, 0, 0, 1,     "rd_mem_en_c1");
    expect_lit(c0 + 1, 1, 0, 14,    "rd_mem_addr_c1");
    expect_lit(c0 + 1, 6, 0, 1,     "rd_stall_c1");
    expect_lit(c0 + 2, 2, 0, 1,     "rd_cpu_ack_c2");
    expect_lit(c0 + 2, 4, 0, 8'h2A, "rd_cpu_rdata_c2");
    expect_lit(c0 + 2, 6, 0, 0,     "rd_stall_c2");
    repeat (3) tick();
    bus.cpu_req = 1'b0;

    // Fresh reset, then both ports request together and keep requesting.
    tick(); reset = 1'b0;
    tick(); reset = 1'b1;
    c0 = cyc;
    bus.cpu_req  = 1'b1; bus.cpu_we  = 1'b0; bus.cpu_addr  = 4'd3;
    bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 4'd9;
    for (int k = 1; k <= 6; k++) begin
      expect_lit(c0 + k, 0, 0, k % 2, "alt_mem_en");
      if (k % 2 == 1) expect_lit(c0 + k, 1, 0, (k == 3) ? 9 : 3, "alt_mem_addr");
      else begin
        expect_lit(c0 + k, 2, 0, int'(k % 4 == 2), "alt_cpu_ack");
        expect_lit(c0 + k, 3, 0, int'(k % 4 == 0), "alt_host_ack");
      end
    end
    repeat (7) tick();
    bus.cpu_req = 1'b0;
    repeat (2) tick();
    bus.host_req = 1'b0;
    tick();

    // Host program load under lock while the core keeps asking.
    bus.host_lock = 1'b1; forbid_cpu_ack = 1'b1;
    bus.cpu_req  = 1'b1; bus.cpu_we  = 1'b0; bus.cpu_addr  = 4'd1;
    bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 4'd0; bus.host_wdata = 8'hC5;
    wait_ack(1'b1, 8, "timeout_host_load0");
    tick();
    bus.host_addr = 4'd1; bus.host_wdata = 8'hF0;
    wait_ack(1'b1, 8, "timeout_host_load1");
    tick();
    bus.host_req = 1'b0;
    expect_lit(cyc, 8, 0, 8'hC5, "load_word0");
    expect_lit(cyc, 8, 1, 8'hF0, "load_word1");
    repeat (2) tick();
    bus.host_lock = 1'b0; forbid_cpu_ack = 1'b0;
    wait_ack(1'b0, 4, "timeout_unlock_cpu");
    expect_lit(cyc, 4, 0, 8'hF0, "unlock_cpu_rdata");
    tick();
    bus.cpu_req = 1'b0;
    tick();

    // Core write then read-back of word 14.
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 4'd14; bus.cpu_wdata = 8'h07;
    wait_ack(1'b0, 4, "timeout_wr");
    expect_lit(cyc, 4, 0, 8'hF0, "wr_keeps_rdata");
    tick();
    bus.cpu_we = 1'b0;
    wait_ack(1'b0, 4, "timeout_rd_back");
    expect_lit(cyc, 4, 0, 8'h07, "rd_back_value");
    tick();
    bus.cpu_req = 1'b0;
    tick();

    // Reset during a host access; afterwards only the core asks.
    c0 = cyc;
    bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 4'd5;
    expect_lit(c0 + 1, 0, 0, 0, "midrst_mem_en");
    expect_lit(c0 + 1, 1, 0, 0, "midrst_mem_addr");
    expect_lit(c0 + 1, 3, 0, 0, "midrst_host_ack");
    expect_lit(c0 + 1, 4, 0, 0, "midrst_cpu_rdata");
    tick();
    reset = 1'b0;
    bus.host_req = 1'b0;
    #1;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 4'd2;
    tick();
    reset = 1'b1;
    c0 = cyc;
    expect_lit(c0 + 1, 0, 0, 1, "postrst_mem_en");
    expect_lit(c0 + 1, 1, 0, 2, "postrst_mem_addr");
    expect_lit(c0 + 2, 2, 0, 1, "postrst_cpu_ack");
    repeat (3) tick();
    bus.cpu_req = 1'b0;
    tick();

    // Lock rising during a core access must not cancel it.
    c0 = cyc;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 4'd14;
    expect_lit(c0 + 1, 0, 0, 1,     "lockedge_mem_en");
    expect_lit(c0 + 2, 2, 0, 1,     "lockedge_cpu_ack");
    expect_lit(c0 + 2, 4, 0, 8'h07, "lockedge_cpu_rdata");
    tick();
    bus.host_lock = 1'b1;
    repeat (2) tick();
    forbid_cpu_ack = 1'b1;
    repeat (6) tick();
    forbid_cpu_ack = 1'b0;
    bus.host_lock = 1'b0;
    wait_ack(1'b0, 4, "timeout_lockedge_release");
    tick();
    bus.cpu_req = 1'b0;
    tick();

    // Randomized traffic; the reference model checks every cycle.
    cack = 1'b0;
    hack = 1'b0;
    for (int i = 0; i < N_RAND; i++) begin
      if (cack) begin
        if ($urandom_range(1) == 0) bus.cpu_req = 1'b0;
        else new_cpu();
      end else if (!bus.cpu_req && $urandom_range(3) == 0) begin
        new_cpu();
      end
      if (hack) begin
        if ($urandom_range(1) == 0) bus.host_req = 1'b0;
        else new_host();
      end else if (!bus.host_req && $urandom_range(3) == 0) begin
        new_host();
      end
      if ($urandom_range(19) == 0) bus.host_lock = ~bus.host_lock;
      #1;
      cack = bus.cpu_ack;
      hack = bus.host_ack;
      tick();
    end

    bus.cpu_req   = 1'b0;
    bus.host_req  = 1'b0;
    bus.host_lock = 1'b0;
    repeat (8) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
